// File: rtl/divide_signed.sv
// Multi-cycle signed/unsigned integer divider: restoring shift-subtract on operand
// magnitudes, one quotient bit per cycle, followed by a single sign-fix cycle.
module divide_signed #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    input  logic         stb,
    output logic         busy,
    output logic         ack,
    output logic [W-1:0] q,
    output logic [W-1:0] r
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    localparam int CW = $clog2(W);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [W:0]     rem;
    logic [W:0]     dvs;
    logic [W-1:0]   quo;
    logic           q_neg;
    logic           r_neg;
    logic           div_zero;

    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W:0]     rem_sh;
    logic           take;
    logic [W-1:0]   q_res;
    logic [W-1:0]   r_res;

    assign a_neg = is_signed & a[W-1];
    assign b_neg = is_signed & b[W-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    // Partial remainder and divisor are W+1 bits so a shifted remainder never overflows.
    assign rem_sh = (rem << 1) | {{W{1'b0}}, quo[W-1]};
    assign take   = (rem_sh >= dvs);

    assign q_res = q_neg ? (~quo + 1'b1) : quo;
    assign r_res = r_neg ? (~rem[W-1:0] + 1'b1) : rem[W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (stb) state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack      <= 1'b0;
            q        <= '0;
            r        <= '0;
            cnt      <= '0;
            rem      <= '0;
            dvs      <= '0;
            quo      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (stb) begin
                        cnt      <= CW'(W - 1);
                        rem      <= '0;
                        quo      <= a_mag;
                        dvs      <= {1'b0, b_mag};
                        q_neg    <= a_neg ^ b_neg;
                        r_neg    <= a_neg;
                        div_zero <= (b == '0);
                    end
                end
                RUN: begin
                    rem <= take ? (rem_sh - dvs) : rem_sh;
                    quo <= {quo[W-2:0], take};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    // A zero divisor leaves the remainder at |a|, so r_res already equals a.
                    q   <= div_zero ? '1 : q_res;
                    r   <= r_res;
                    ack <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divide_signed.sv
// Self-checking bench for divide_signed (W = 32): directed corner cases, back-to-back,
// reset abort and randomized operations against a plain-arithmetic reference model.
module tb_divide_signed;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         is_signed;
    logic         stb;
    logic         busy;
    logic         ack;
    logic [W-1:0] q;
    logic [W-1:0] r;

    int checks   = 0;
    int failures = 0;

    divide_signed #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .stb       (stb),
        .busy      (busy),
        .ack       (ack),
        .q         (q),
        .r         (r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Truncating division; zero divisor and signed overflow handled explicitly.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic ms, output logic [W-1:0] eq,
                                  output logic [W-1:0] er);
        int sa;
        int sb;
        if (mb == 0) begin
            eq = '1;
            er = ma;
        end else if (ms) begin
            if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                eq = ma;
                er = '0;
            end else begin
                sa = $signed(ma);
                sb = $signed(mb);
                eq = sa / sb;
                er = sa % sb;
            end
        end else begin
            eq = ma / mb;
            er = ma % mb;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; caller ensures the DUT is idle.
    task automatic start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        a = ta;
        b = tb;
        is_signed = ts;
        stb = 1'b1;
        step();
        stb = 1'b0;
        a = $urandom;
        b = $urandom;
        is_signed = $urandom_range(0, 1);
    endtask

    // Waits (bounded) for ack after an accept edge, checking latency, busy duration,
    // result hold during RUN and the result itself.
    task automatic finish(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input bit check_pulse);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic [W-1:0] q_prev;
        logic [W-1:0] r_prev;
        int n;
        int busy_cnt;
        bit held;
        model(ta, tb, ts, eq, er);
        q_prev = q;
        r_prev = r;
        held = 1'b1;
        n = 0;
        busy_cnt = 0;
        while (!ack && n < 200) begin
            if (busy) busy_cnt++;
            if (q !== q_prev || r !== r_prev) held = 1'b0;
            step();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(W + 1));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
        check({tag, " hold"}, 64'(held), 64'd1);
        check({tag, " q"}, 64'(q), 64'(eq));
        check({tag, " r"}, 64'(r), 64'(er));
        check({tag, " busy_in_ack"}, 64'(busy), 64'd0);
        if (check_pulse) begin
            step();
            check({tag, " ack_pulse"}, 64'(ack), 64'd0);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts);
        start(ta, tb, ts);
        finish(tag, ta, tb, ts, 1'b1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        int           acks;

        rst = 1'b1;
        stb = 1'b1;
        a = 32'd3;
        b = 32'd1;
        is_signed = 1'b0;
        step();
        step();
        check("reset busy", 64'(busy), 64'd0);
        check("reset ack", 64'(ack), 64'd0);
        check("reset q", 64'(q), 64'd0);
        check("reset r", 64'(r), 64'd0);
        stb = 1'b0;
        rst = 1'b0;
        step();
        check("idle busy", 64'(busy), 64'd0);

        run_op("s100/7", 32'd100, 32'd7, 1'b1);
        run_op("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("u-7/2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("s5/0", 32'd5, 32'd0, 1'b1);
        run_op("u5/0", 32'd5, 32'd0, 1'b0);
        run_op("s-5/0", 32'hFFFF_FFFB, 32'd0, 1'b1);
        run_op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("smin/1", 32'h8000_0000, 32'd1, 1'b1);
        run_op("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1);

        // Back-to-back with stb held high; operands shown while busy must be ignored.
        a = 32'd9;
        b = 32'd3;
        is_signed = 1'b1;
        stb = 1'b1;
        step();
        a = 32'd1000;
        b = 32'd1;
        finish("b2b1", 32'd9, 32'd3, 1'b1, 1'b0);
        a = 32'd10;
        b = 32'd4;
        step();
        check("b2b accept busy", 64'(busy), 64'd1);
        check("b2b accept ack", 64'(ack), 64'd0);
        a = 32'd77;
        b = 32'd5;
        finish("b2b2", 32'd10, 32'd4, 1'b1, 1'b0);
        stb = 1'b0;
        step();

        // Reset in the middle of RUN aborts the operation without an ack.
        start(32'd1234, 32'd5, 1'b0);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort ack", 64'(ack), 64'd0);
        check("abort q", 64'(q), 64'd0);
        check("abort r", 64'(r), 64'd0);
        acks = 0;
        repeat (W + 5) begin
            if (ack) acks++;
            step();
        end
        check("abort no_ack", 64'(acks), 64'd0);
        run_op("after_abort", 32'hFFFF_FF9C, 32'd7, 1'b1);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rs = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = '1;
                2: rb = 32'($urandom_range(1, 20));
                3: begin ra = 32'h8000_0000; rb = $urandom; end
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op($sformatf("rand%0d", i), ra, rb, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
